// File: rtl/fp8_pkg.sv
// Shared fp8 word layout: [7] sign, [6:4] exponent (0 = zero), [3:0] fraction with implied 1.
package fp8_pkg;
  localparam int FP8_EXP_W  = 3;
  localparam int FP8_FRAC_W = 4;
  localparam int FP8_W      = 1 + FP8_EXP_W + FP8_FRAC_W;

  localparam logic [FP8_W-1:0] FP8_ZERO    = 8'h00;
  localparam logic [FP8_W-2:0] FP8_SAT_MAG = 7'h7F;

  typedef enum logic [1:0] {IDLE, NORM, DONE} fp8_state_e;

  function automatic logic fp8_sign(input logic [FP8_W-1:0] w);
    return w[FP8_W-1];
  endfunction

  function automatic logic [FP8_EXP_W-1:0] fp8_exp(input logic [FP8_W-1:0] w);
    return w[FP8_W-2 -: FP8_EXP_W];
  endfunction

  function automatic logic [FP8_FRAC_W-1:0] fp8_frac(input logic [FP8_W-1:0] w);
    return w[FP8_FRAC_W-1:0];
  endfunction

  function automatic logic [FP8_W-1:0] fp8_pack(input logic s,
                                                input logic [FP8_EXP_W-1:0] e,
                                                input logic [FP8_FRAC_W-1:0] f);
    return {s, e, f};
  endfunction
endpackage

// File: rtl/fp8_int_to_float_if.sv
// Integer-in / fp8-out handshake bundle; slave is the converter, master the surrounding logic.
interface fp8_int_to_float_if #(
  parameter int IN_W   = 8,
  parameter int EXP_W  = 3,
  parameter int FRAC_W = 4
);
  logic [IN_W-1:0]         in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic [EXP_W+FRAC_W:0]   out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_zero;
  logic                    out_ovf;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_zero, out_ovf
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_zero, out_ovf
  );
endinterface

// File: rtl/fp8_int_to_float.sv
// Signed int -> fp8, normalised one left shift per clock; 1..IN_W edges from accept to out_valid.
// One conversion in flight: in_ready only in IDLE, result held in DONE until out_ready.
module fp8_int_to_float
  import fp8_pkg::*;
#(
  parameter int IN_W   = 8,
  parameter int EXP_W  = FP8_EXP_W,
  parameter int FRAC_W = FP8_FRAC_W
) (
  input logic               clk,
  input logic               rst_n,
  fp8_int_to_float_if.slave bus
);
  localparam int CNT_W = $clog2(IN_W);
  localparam int OUT_W = 1 + EXP_W + FRAC_W;
  localparam logic [CNT_W:0] EXP_MAX = (CNT_W+1)'((1 << EXP_W) - 1);
  localparam logic [CNT_W:0] EXP_TOP = (CNT_W+1)'(IN_W);

  fp8_state_e       state, state_n;
  logic             sign, sign_n;
  logic [IN_W-1:0]  mag, mag_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [OUT_W-1:0] data_q, data_n;
  logic             vld_q, vld_n;
  logic             zero_q, zero_n;
  logic             ovf_q, ovf_n;
  logic [CNT_W:0]   exp_full;

  assign exp_full = EXP_TOP - {1'b0, cnt};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      sign   <= 1'b0;
      mag    <= '0;
      cnt    <= '0;
      data_q <= '0;
      vld_q  <= 1'b0;
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      state  <= state_n;
      sign   <= sign_n;
      mag    <= mag_n;
      cnt    <= cnt_n;
      data_q <= data_n;
      vld_q  <= vld_n;
      zero_q <= zero_n;
      ovf_q  <= ovf_n;
    end
  end

  always_comb begin
    state_n = state;
    sign_n  = sign;
    mag_n   = mag;
    cnt_n   = cnt;
    data_n  = data_q;
    vld_n   = vld_q;
    zero_n  = zero_q;
    ovf_n   = ovf_q;
    case (state)
      IDLE: begin
        if (bus.in_valid && bus.in_ready) begin
          sign_n  = bus.in_data[IN_W-1];
          mag_n   = bus.in_data[IN_W-1] ? (~bus.in_data + 1'b1) : bus.in_data;
          cnt_n   = '0;
          state_n = NORM;
        end
      end
      NORM: begin
        if (mag == '0) begin
          // zero is always +0, regardless of the captured sign
          data_n  = '0;
          zero_n  = 1'b1;
          vld_n   = 1'b1;
          state_n = DONE;
        end else if (mag[IN_W-1]) begin
          if (exp_full > EXP_MAX) begin
            data_n = {sign, {(EXP_W+FRAC_W){1'b1}}};
            ovf_n  = 1'b1;
          end else begin
            data_n = {sign, exp_full[EXP_W-1:0], mag[IN_W-2 -: FRAC_W]};
          end
          vld_n   = 1'b1;
          state_n = DONE;
        end else begin
          mag_n = mag << 1;
          cnt_n = cnt + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          vld_n   = 1'b0;
          zero_n  = 1'b0;
          ovf_n   = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.in_ready  = rst_n && (state == IDLE);
  assign bus.out_data  = data_q;
  assign bus.out_valid = vld_q;
  assign bus.out_zero  = zero_q;
  assign bus.out_ovf   = ovf_q;
endmodule

// File: tb/tb_fp8_int_to_float.sv
// Directed-vector bench for fp8_int_to_float: values, latencies, backpressure and mid-flight reset.
module tb_fp8_int_to_float;
  import fp8_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  fp8_int_to_float_if #(.IN_W(8), .EXP_W(3), .FRAC_W(4)) bus ();

  fp8_int_to_float #(.IN_W(8), .EXP_W(3), .FRAC_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic convert(input string tag, input logic [7:0] d, input int lat,
                         input logic [7:0] exp_d, input logic exp_z, input logic exp_o);
    int edges;
    check({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    edges = 0;
    while (!bus.out_valid && edges < 20) begin
      step();
      edges++;
    end
    check({tag, ".out_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, ".latency"}, 32'(edges), 32'(lat));
    check({tag, ".out_data"}, 32'(bus.out_data), 32'(exp_d));
    check({tag, ".out_zero"}, 32'(bus.out_zero), 32'(exp_z));
    check({tag, ".out_ovf"}, 32'(bus.out_ovf), 32'(exp_o));
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check({tag, ".handoff_vld"}, 32'(bus.out_valid), 32'd0);
    check({tag, ".handoff_rdy"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    int edges;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;

    step();
    step();
    check("rst.out_data", 32'(bus.out_data), 32'h00);
    check("rst.out_valid", 32'(bus.out_valid), 32'd0);
    check("rst.out_zero", 32'(bus.out_zero), 32'd0);
    check("rst.out_ovf", 32'(bus.out_ovf), 32'd0);
    check("rst.in_ready", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst.in_ready_rel", 32'(bus.in_ready), 32'd1);

    convert("p5",    8'h05, 6, 8'h34, 1'b0, 1'b0);
    check("p5.exp_field", 32'(fp8_exp(bus.out_data)), 32'd3);
    check("p5.frac_field", 32'(fp8_frac(bus.out_data)), 32'h4);
    convert("n6",    8'hFA, 6, 8'hB8, 1'b0, 1'b0);
    check("n6.sign_field", 32'(fp8_sign(bus.out_data)), 32'd1);
    convert("zero",  8'h00, 1, 8'h00, 1'b1, 1'b0);
    convert("n128",  8'h80, 1, 8'hFF, 1'b0, 1'b1);
    convert("p127",  8'h7F, 2, 8'h7F, 1'b0, 1'b0);
    convert("p1",    8'h01, 8, 8'h10, 1'b0, 1'b0);
    convert("n1",    8'hFF, 8, 8'h90, 1'b0, 1'b0);
    convert("p64",   8'h40, 2, 8'h70, 1'b0, 1'b0);

    // backpressure with a competing request held during the busy window
    bus.in_data  = 8'h05;
    bus.in_valid = 1'b1;
    step();
    bus.in_data  = 8'h01;
    check("bp.busy_rdy", 32'(bus.in_ready), 32'd0);
    edges = 0;
    while (!bus.out_valid && edges < 20) begin
      step();
      edges++;
    end
    check("bp.latency", 32'(edges), 32'd6);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp.hold_data%0d", i), 32'(bus.out_data), 32'h34);
      check($sformatf("bp.hold_vld%0d", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("bp.hold_rdy%0d", i), 32'(bus.in_ready), 32'd0);
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("bp.idle_rdy", 32'(bus.in_ready), 32'd1);
    check("bp.idle_vld", 32'(bus.out_valid), 32'd0);
    for (int i = 0; i < 10; i++) step();
    check("bp.no_second_vld", 32'(bus.out_valid), 32'd0);
    check("bp.no_second_rdy", 32'(bus.in_ready), 32'd1);

    // reset while normalising the input 1
    bus.in_data  = 8'h01;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    step();
    check("mrst.out_valid", 32'(bus.out_valid), 32'd0);
    check("mrst.out_data", 32'(bus.out_data), 32'h00);
    check("mrst.in_ready", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    check("mrst.in_ready_rel", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 10; i++) step();
    check("mrst.no_vld", 32'(bus.out_valid), 32'd0);
    convert("mrst.p5", 8'h05, 6, 8'h34, 1'b0, 1'b0);

    // out_ready held high: single result per conversion
    bus.out_ready = 1'b1;
    bus.in_data   = 8'h0C;
    bus.in_valid  = 1'b1;
    step();
    bus.in_valid = 1'b0;
    edges = 0;
    while (!bus.out_valid && edges < 20) begin
      step();
      edges++;
    end
    check("ordy.latency", 32'(edges), 32'd5);
    check("ordy.out_data", 32'(bus.out_data), 32'h48);
    step();
    check("ordy.vld_clear", 32'(bus.out_valid), 32'd0);
    for (int i = 0; i < 10; i++) step();
    check("ordy.no_repeat", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
